// File: rtl/sum_acc_pkg.sv
// Shared types and widths for the sum accumulator block.
package sum_acc_pkg;

    // Operand / Sum width and entry-counter width.
    localparam int SUM_W = 4;
    localparam int CNT_W = 3;

    // Round state: accepting entries, or round over with outputs frozen.
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

endpackage : sum_acc_pkg

// File: rtl/sum_accumulator_if.sv
// Switch/button inputs and result outputs of the sum accumulator.
interface sum_accumulator_if
    import sum_acc_pkg::*;
#(
    parameter int WIDTH = SUM_W
);
    logic [WIDTH-1:0] Operand;
    logic             Enter;
    logic             Clear;
    logic [WIDTH-1:0] Sum;
    logic [CNT_W-1:0] EntryCount;
    logic             Done;
    logic             Overflow;

    // Stimulus side: drives operand and pulses, observes results.
    modport master (
        output Operand, Enter, Clear,
        input  Sum, EntryCount, Done, Overflow
    );

    // Accumulator side.
    modport slave (
        input  Operand, Enter, Clear,
        output Sum, EntryCount, Done, Overflow
    );
endinterface : sum_accumulator_if

// File: rtl/sum_accumulator_entry_counter.sv
// Entries-per-round counter: sync clear, count enable, terminal flag when
// the next accepted entry would be the last one allowed.
module entry_counter
    import sum_acc_pkg::*;
#(
    parameter int CW          = CNT_W,
    parameter int MAX_ENTRIES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          terminal
);
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_ENTRIES - 1);
    localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = (count_q == LAST_IDX);

endmodule : entry_counter

// File: rtl/sum_accumulator.sv
// Running-sum accumulator: adds one switch operand per Enter pulse and ends
// the round on target hit, entry limit or overflow; Clear starts a new round.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int WIDTH       = SUM_W,
    parameter int TARGET      = 15,
    parameter int MAX_ENTRIES = 4
) (
    input logic              clk,
    input logic              rst,
    sum_accumulator_if.slave bus
);
    localparam logic [WIDTH:0] TARGET_EXT = (WIDTH + 1)'(TARGET);

    acc_state_e       state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             cnt_en_s;
    logic             cnt_clr_s;
    logic             cnt_last_s;
    logic [CNT_W-1:0] cnt_s;
    logic [WIDTH:0]   sum_ext_s;

    // Carry-extended sum so overflow is detected instead of wrapping.
    assign sum_ext_s = {1'b0, sum_q} + {1'b0, bus.Operand};

    entry_counter #(
        .CW          (CNT_W),
        .MAX_ENTRIES (MAX_ENTRIES)
    ) u_entry_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr_s),
        .en       (cnt_en_s),
        .count    (cnt_s),
        .terminal (cnt_last_s)
    );

    // Round FSM: next state, next sum and status flags; Clear beats Enter.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        cnt_en_s  = 1'b0;
        cnt_clr_s = 1'b0;
        if (bus.Clear) begin
            state_d   = ACCUM;
            sum_d     = '0;
            done_d    = 1'b0;
            ovf_d     = 1'b0;
            cnt_clr_s = 1'b1;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.Enter) begin
                        if (sum_ext_s[WIDTH]) begin
                            // Reject the entry: Sum and count stay put.
                            ovf_d   = 1'b1;
                            done_d  = 1'b1;
                            state_d = HOLD;
                        end else begin
                            sum_d    = sum_ext_s[WIDTH-1:0];
                            cnt_en_s = 1'b1;
                            if ((sum_ext_s == TARGET_EXT) || cnt_last_s) begin
                                done_d  = 1'b1;
                                state_d = HOLD;
                            end else begin
                                state_d = ACCUM;
                            end
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
                HOLD: begin
                    state_d = HOLD;
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            sum_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.Sum        = sum_q;
    assign bus.EntryCount = cnt_s;
    assign bus.Done       = done_q;
    assign bus.Overflow   = ovf_q;

endmodule : sum_accumulator
